// File: rtl/led_seq_pkg.sv
// Shared types and timebase helper for the LED blink sequencer.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_SOLID = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_BURST = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SOLID = 2'd1,
    ST_BLINK = 2'd2,
    ST_BURST = 2'd3
  } state_e;

  function automatic int tick_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every CLK_FREQ_HZ/TICK_HZ cycles; clr restarts the count.
module tick_prescaler
  import led_seq_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 48_000_000,
  parameter int TICK_HZ     = 1_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int DIV = tick_div(CLK_FREQ_HZ, TICK_HZ);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/led_blink_sequencer.sv
// Command-driven LED sequencer (off / solid / blink / counted burst) with ms-tick timing.
// Optional PWM dimming of the on-phase is enabled by defining LED_SEQ_PWM_EN.
module led_blink_sequencer
  import led_seq_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 48_000_000,
  parameter int TICK_HZ     = 1_000,
  parameter int PWM_BITS    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_mode,
  input  logic [15:0]         cmd_half,
  input  logic [7:0]          cmd_count,
`ifdef LED_SEQ_PWM_EN
  input  logic [PWM_BITS-1:0] cmd_duty,
`endif
  output logic                busy,
  output logic                done,
  output logic                led
);

  state_e      state_q, state_d;
  logic        on_q, on_d;
  logic [15:0] phase_cnt_q, phase_cnt_d;
  logic [7:0]  pulse_cnt_q, pulse_cnt_d;
  logic        done_q, done_d;
  logic [15:0] half_q;
  logic        accept, tick, phase_last, on_level;

  assign busy      = (state_q == ST_BURST);
  assign cmd_ready = ~busy;
  assign done      = done_q;
  assign accept    = cmd_valid && cmd_ready;

  tick_prescaler #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ),
    .TICK_HZ    (TICK_HZ)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clr  (accept),
    .tick (tick)
  );

  assign phase_last = (phase_cnt_q == half_q - 16'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      on_q        <= 1'b0;
      phase_cnt_q <= '0;
      pulse_cnt_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      on_q        <= on_d;
      phase_cnt_q <= phase_cnt_d;
      pulse_cnt_q <= pulse_cnt_d;
      done_q      <= done_d;
    end
  end

  // Command fields are pure data; they are only meaningful after an accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      half_q <= (cmd_half == 16'd0) ? 16'd1 : cmd_half;
    end
  end

  // An accepted command always takes priority over any phase end in the same cycle.
  always_comb begin
    state_d     = state_q;
    on_d        = on_q;
    phase_cnt_d = phase_cnt_q;
    pulse_cnt_d = pulse_cnt_q;
    done_d      = 1'b0;
    if (accept) begin
      phase_cnt_d = '0;
      pulse_cnt_d = '0;
      case (mode_e'(cmd_mode))
        MODE_OFF: begin
          state_d = ST_IDLE;
          on_d    = 1'b0;
        end
        MODE_SOLID: begin
          state_d = ST_SOLID;
          on_d    = 1'b1;
        end
        MODE_BLINK: begin
          state_d = ST_BLINK;
          on_d    = 1'b1;
        end
        MODE_BURST: begin
          state_d     = ST_BURST;
          pulse_cnt_d = cmd_count;
          on_d        = (cmd_count != 8'd0);
          done_d      = (cmd_count == 8'd0);
        end
        default: ;
      endcase
    end else begin
      case (state_q)
        ST_BLINK: begin
          if (tick) begin
            if (phase_last) begin
              phase_cnt_d = '0;
              on_d        = ~on_q;
            end else begin
              phase_cnt_d = phase_cnt_q + 16'd1;
            end
          end
        end
        ST_BURST: begin
          if (done_q) begin
            state_d     = ST_IDLE;
            on_d        = 1'b0;
            phase_cnt_d = '0;
          end else if (tick) begin
            if (phase_last) begin
              phase_cnt_d = '0;
              if (on_q) begin
                on_d = 1'b0;
              end else if (pulse_cnt_q == 8'd1) begin
                done_d      = 1'b1;
                pulse_cnt_d = '0;
              end else begin
                pulse_cnt_d = pulse_cnt_q - 8'd1;
                on_d        = 1'b1;
              end
            end else begin
              phase_cnt_d = phase_cnt_q + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign on_level = (state_q == ST_SOLID) ||
                    (on_q && ((state_q == ST_BLINK) || (state_q == ST_BURST)));

`ifdef LED_SEQ_PWM_EN
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      duty_q <= cmd_duty;
    end
  end

  assign led = on_level && (pwm_cnt <= duty_q);
`else
  assign led = on_level;
`endif

endmodule

// File: tb/tb_led_blink_sequencer.sv
// Directed plus randomized bench for led_blink_sequencer against a cycle-index reference model.
module tb_led_blink_sequencer;

  localparam int CLK_FREQ_HZ = 10_000;
  localparam int TICK_HZ     = 1_000;
  localparam int PWM_BITS    = 4;
  localparam int DIV         = CLK_FREQ_HZ / TICK_HZ;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_mode = 2'd0;
  logic [15:0] cmd_half = 16'd0;
  logic [7:0]  cmd_count = 8'd0;
  logic        cmd_ready, busy, done, led;
`ifdef LED_SEQ_PWM_EN
  logic [PWM_BITS-1:0] cmd_duty = '1;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic led;
    logic busy;
    logic done;
  } exp_t;

  led_blink_sequencer #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ),
    .TICK_HZ    (TICK_HZ),
    .PWM_BITS   (PWM_BITS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_mode (cmd_mode),
    .cmd_half (cmd_half),
    .cmd_count(cmd_count),
`ifdef LED_SEQ_PWM_EN
    .cmd_duty (cmd_duty),
`endif
    .busy     (busy),
    .done     (done),
    .led      (led)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected outputs n cycles after the accept edge (n=1 is the first cycle after accept).
  function automatic exp_t model(input int mode, input int half, input int count, input int n);
    int   h = ((half == 0) ? 1 : half) * DIV;
    int   t = 2 * h * count;
    exp_t e = '0;
    case (mode)
      1: e.led = 1'b1;
      2: e.led = (((n - 1) / h) % 2) == 0;
      3: begin
        if (n <= t) begin
          e.led  = (((n - 1) / h) % 2) == 0;
          e.busy = 1'b1;
        end else if (n == t + 1) begin
          e.busy = 1'b1;
          e.done = 1'b1;
        end
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic issue(input int mode, input int half, input int count);
    int waited = 0;
    @(posedge clk); #1;
    while (!cmd_ready && waited < 1000) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!cmd_ready) chk("issue_ready_timeout", 32'(cmd_ready), 32'd1);
    cmd_mode  = mode[1:0];
    cmd_half  = half[15:0];
    cmd_count = count[7:0];
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic check_run(input string tag, input int mode, input int half, input int count,
                           input int ncyc);
    exp_t e;
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      e = model(mode, half, count, n);
      chk($sformatf("%s_led@%0d", tag, n), 32'(led), 32'(e.led));
      chk($sformatf("%s_busy@%0d", tag, n), 32'(busy), 32'(e.busy));
      chk($sformatf("%s_done@%0d", tag, n), 32'(done), 32'(e.done));
      chk($sformatf("%s_ready@%0d", tag, n), 32'(cmd_ready), 32'(!e.busy));
    end
  endtask

  initial begin
    int   m, h, c, nc;
    exp_t e;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    reset = 1'b0;

    // BLINK half=3: 30 on / 30 off, first high right after accept
    issue(2, 3, 0);
    check_run("blink3", 2, 3, 0, 130);

    // BURST half=2 count=3: done at cycle 121, busy throughout
    issue(3, 2, 3);
    check_run("burst3", 3, 2, 3, 125);

    // BURST count=0: immediate done, LED never lit
    issue(3, 7, 0);
    check_run("burst0", 3, 7, 0, 5);

    // BLINK half=5 preempted by SOLID exactly on the first phase-end cycle (cycle 50)
    issue(2, 5, 0);
    check_run("blink5", 2, 5, 0, 49);
    issue(1, 0, 0);
    check_run("solid_pre", 1, 0, 0, 40);

    // Command held during a burst is accepted on the cycle after done
    issue(3, 1, 2);
    cmd_mode  = 2'd1;
    cmd_half  = 16'd1;
    cmd_count = 8'd0;
    cmd_valid = 1'b1;
    for (int n = 1; n <= 41; n++) begin
      @(negedge clk);
      e = model(3, 1, 2, n);
      chk($sformatf("hold_led@%0d", n), 32'(led), 32'(e.led));
      chk($sformatf("hold_done@%0d", n), 32'(done), 32'(e.done));
      chk($sformatf("hold_ready@%0d", n), 32'(cmd_ready), 32'd0);
    end
    @(negedge clk);
    chk("hold_after_ready", 32'(cmd_ready), 32'd1);
    chk("hold_after_led", 32'(led), 32'd0);
    chk("hold_after_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("hold_solid_led", 32'(led), 32'd1);
    chk("hold_solid_busy", 32'(busy), 32'd0);
    issue(0, 0, 0);
    check_run("off", 0, 0, 0, 10);

    // Randomized command sequence; non-burst modes are preempted at random points
    for (int k = 0; k < 10; k++) begin
      m  = int'($urandom_range(0, 3));
      h  = int'($urandom_range(0, 4));
      c  = int'($urandom_range(0, 3));
      nc = (m == 3) ? 2 * ((h == 0) ? 1 : h) * DIV * c + 3 : int'($urandom_range(5, 90));
      issue(m, h, c);
      check_run($sformatf("rnd%0d_m%0d_h%0d_c%0d", k, m, h, c), m, h, c, nc);
    end

    // Asynchronous reset mid-burst: outputs drop without a clock edge, no done pulse
    issue(3, 2, 3);
    check_run("preabort", 3, 2, 3, 30);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_led", 32'(led), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(cmd_ready), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("abort_hold_done", 32'(done), 32'd0);
      chk("abort_hold_led", 32'(led), 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    check_run("post_reset", 0, 0, 0, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
